ac97_sdata_in_receiver: RTL and testbench



---
 rtl/ac97_pkg.sv | 26 ++
 rtl/ac97_frame_counter.sv | 94 +++++++++
 rtl/ac97_sdata_in_receiver.sv | 110 +++++++++++
 tb/tb_ac97_sdata_in_receiver.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ac97_pkg.sv
// Shared constants, tag bit positions and receive FSM states for the AC97 SDATA_IN deframer.
package ac97_pkg;

  localparam int AC97_FRAME_BITS = 256;
  localparam int AC97_TAG_BITS   = 16;
  localparam int AC97_SLOT_BITS  = 20;

  localparam logic [7:0] SLOT0_END = 8'd15;
  localparam logic [7:0] SLOT1_END = 8'd35;
  localparam logic [7:0] SLOT2_END = 8'd55;
  localparam logic [7:0] SLOT3_END = 8'd75;
  localparam logic [7:0] SLOT4_END = 8'd95;
  localparam logic [7:0] FRAME_END = 8'(AC97_FRAME_BITS - 1);

  localparam int TAG_CODEC_READY = 15;

  function automatic int slot_valid_bit(input int n);
    return 15 - n;
  endfunction

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } rx_state_e;

endpackage

// File: rtl/ac97_frame_counter.sv
// Frame-start detect, HUNT/RECV sequencing, bit counter and slot-end strobes.
// Optional AC97_RX_FRAME_CHECK_EN adds SYNC-shape checking and drop-to-HUNT on error.
//
// state | meaning
// HUNT  | waiting for a SYNC rising edge; sdata_in ignored
// RECV  | bit_cnt tracks the frame position 0..255, wrapping
module ac97_frame_counter
  import ac97_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sync,
  output logic recv,
  output logic locked,
  output logic frame_error,
  output logic end_slot0,
  output logic end_slot1,
  output logic end_slot2,
  output logic end_slot3,
  output logic end_slot4,
  output logic end_frame
);

  rx_state_e  state, state_nx;
  logic [7:0] bit_cnt, cnt_nx;
  logic       sync_q;
  logic       locked_nx;
  logic       err_nx;
  logic       frame_start;

  assign frame_start = sync & ~sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      bit_cnt     <= 8'd0;
      sync_q      <= 1'b0;
      locked      <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_nx;
      bit_cnt     <= cnt_nx;
      sync_q      <= sync;
      locked      <= locked_nx;
      frame_error <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = bit_cnt;
    locked_nx = locked;
    err_nx    = 1'b0;
    case (state)
      HUNT: begin
        if (frame_start) begin
          state_nx  = RECV;
          cnt_nx    = 8'd0;
          locked_nx = 1'b1;
        end
      end
      RECV: begin
        cnt_nx = bit_cnt + 8'd1;
        // An early SYNC edge restarts the frame; the partial frame is abandoned.
        if (frame_start && (bit_cnt != FRAME_END)) begin
          cnt_nx = 8'd0;
`ifdef AC97_RX_FRAME_CHECK_EN
          err_nx = 1'b1;
`endif
        end
`ifdef AC97_RX_FRAME_CHECK_EN
        if ((!sync && (bit_cnt < SLOT0_END)) ||
            (sync && (bit_cnt > SLOT0_END) && (bit_cnt != FRAME_END)))
          err_nx = 1'b1;
        if (err_nx) begin
          state_nx  = HUNT;
          cnt_nx    = 8'd0;
          locked_nx = 1'b0;
        end
`endif
      end
      default: state_nx = HUNT;
    endcase
  end

  assign recv      = (state == RECV);
  assign end_slot0 = recv && (bit_cnt == SLOT0_END);
  assign end_slot1 = recv && (bit_cnt == SLOT1_END);
  assign end_slot2 = recv && (bit_cnt == SLOT2_END);
  assign end_slot3 = recv && (bit_cnt == SLOT3_END);
  assign end_slot4 = recv && (bit_cnt == SLOT4_END);
  assign end_frame = recv && (bit_cnt == FRAME_END);

endmodule

// File: rtl/ac97_sdata_in_receiver.sv
// AC97 SDATA_IN deframer: recovers slot-0 tag, status addr/data and PCM capture samples.
// Define AC97_RX_FRAME_CHECK_EN to enable SYNC framing checks (frame_error).
module ac97_sdata_in_receiver
  import ac97_pkg::*;
#(
  parameter int PCM_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sync,
  input  logic                 sdata_in,
  output logic                 locked,
  output logic                 codec_ready,
  output logic [6:0]           status_addr,
  output logic [15:0]          status_data,
  output logic                 status_valid,
  output logic [PCM_WIDTH-1:0] pcm_left,
  output logic [PCM_WIDTH-1:0] pcm_right,
  output logic                 pcm_left_vld,
  output logic                 pcm_right_vld,
  output logic                 pcm_valid,
  output logic                 frame_done,
  output logic                 frame_error
);

  logic recv;
  logic end_slot0, end_slot1, end_slot2, end_slot3, end_slot4, end_frame;

  ac97_frame_counter u_frame_counter (
    .clk         (clk),
    .rst         (rst),
    .sync        (sync),
    .recv        (recv),
    .locked      (locked),
    .frame_error (frame_error),
    .end_slot0   (end_slot0),
    .end_slot1   (end_slot1),
    .end_slot2   (end_slot2),
    .end_slot3   (end_slot3),
    .end_slot4   (end_slot4),
    .end_frame   (end_frame)
  );

  logic [AC97_SLOT_BITS-1:0] shreg;
  logic [AC97_SLOT_BITS-1:0] sh_nx;
  logic [AC97_TAG_BITS-1:0]  tag_q;
  logic [6:0]                addr_hold;
  logic [PCM_WIDTH-1:0]      left_hold;
  logic                      status_ok;
  logic                      pcm_ok;

  // Includes the bit sampled on this edge, so a slot is complete when its end strobe is high.
  assign sh_nx     = {shreg[AC97_SLOT_BITS-2:0], sdata_in};
  assign status_ok = tag_q[slot_valid_bit(1)] & tag_q[slot_valid_bit(2)];
  assign pcm_ok    = tag_q[slot_valid_bit(3)] | tag_q[slot_valid_bit(4)];

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg         <= '0;
      tag_q         <= '0;
      addr_hold     <= '0;
      left_hold     <= '0;
      codec_ready   <= 1'b0;
      status_addr   <= '0;
      status_data   <= '0;
      status_valid  <= 1'b0;
      pcm_left      <= '0;
      pcm_right     <= '0;
      pcm_left_vld  <= 1'b0;
      pcm_right_vld <= 1'b0;
      pcm_valid     <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      status_valid <= 1'b0;
      pcm_valid    <= 1'b0;
      frame_done   <= 1'b0;
      if (recv)
        shreg <= sh_nx;
      if (end_slot0) begin
        tag_q       <= sh_nx[AC97_TAG_BITS-1:0];
        codec_ready <= sh_nx[TAG_CODEC_READY];
      end
      if (end_slot1)
        addr_hold <= sh_nx[18:12];
      if (end_slot2 && status_ok) begin
        status_addr  <= addr_hold;
        status_data  <= sh_nx[19:4];
        status_valid <= 1'b1;
      end
      if (end_slot3)
        left_hold <= sh_nx[AC97_SLOT_BITS-1 -: PCM_WIDTH];
      if (end_slot4 && pcm_ok) begin
        pcm_valid     <= 1'b1;
        pcm_left_vld  <= tag_q[slot_valid_bit(3)];
        pcm_right_vld <= tag_q[slot_valid_bit(4)];
        if (tag_q[slot_valid_bit(3)])
          pcm_left <= left_hold;
        if (tag_q[slot_valid_bit(4)])
          pcm_right <= sh_nx[AC97_SLOT_BITS-1 -: PCM_WIDTH];
      end
      if (end_frame)
        frame_done <= 1'b1;
    end
  end

  // Tag bits outside the ready/valid set and the oldest shift bit are never consumed.
  logic unused_bits;
  assign unused_bits = ^{tag_q[15], tag_q[10:0], shreg[AC97_SLOT_BITS-1]};

endmodule

// File: tb/tb_ac97_sdata_in_receiver.sv
// Directed bench for ac97_sdata_in_receiver: full frames, tag variations, resync and mid-frame reset.
module tb_ac97_sdata_in_receiver;

  logic clk = 1'b0;
  logic rst, sync, sdata_in;

  logic        locked, codec_ready, status_valid, pcm_left_vld, pcm_right_vld;
  logic        pcm_valid, frame_done, frame_error;
  logic [6:0]  status_addr;
  logic [15:0] status_data;
  logic [19:0] pcm_left, pcm_right;

  logic        locked16, ready16, sv16, lvld16, rvld16, pv16, fd16, fe16;
  logic [6:0]  addr16;
  logic [15:0] data16;
  logic [15:0] left16, right16;

  always #5 clk = ~clk;

  ac97_sdata_in_receiver #(.PCM_WIDTH(20)) dut (
    .clk(clk), .rst(rst), .sync(sync), .sdata_in(sdata_in),
    .locked(locked), .codec_ready(codec_ready),
    .status_addr(status_addr), .status_data(status_data), .status_valid(status_valid),
    .pcm_left(pcm_left), .pcm_right(pcm_right),
    .pcm_left_vld(pcm_left_vld), .pcm_right_vld(pcm_right_vld),
    .pcm_valid(pcm_valid), .frame_done(frame_done), .frame_error(frame_error)
  );

  ac97_sdata_in_receiver #(.PCM_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .sync(sync), .sdata_in(sdata_in),
    .locked(locked16), .codec_ready(ready16),
    .status_addr(addr16), .status_data(data16), .status_valid(sv16),
    .pcm_left(left16), .pcm_right(right16),
    .pcm_left_vld(lvld16), .pcm_right_vld(rvld16),
    .pcm_valid(pv16), .frame_done(fd16), .frame_error(fe16)
  );

  int checks = 0;
  int errors = 0;
  int sv_n, sv_c, pv_n, pv_c, fd_n, fd_c, fe_n;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clr();
    sv_n = 0; sv_c = -1; pv_n = 0; pv_c = -1; fd_n = 0; fd_c = -1; fe_n = 0;
  endtask

  // Drive one bit at negedge, look at pulses just after the posedge that samples it.
  task automatic tick(input logic s, input logic d, input logic r, input int c);
    sync = s; sdata_in = d; rst = r;
    @(posedge clk);
    #1;
    if (status_valid) begin sv_n++; sv_c = c; end
    if (pcm_valid)    begin pv_n++; pv_c = c; end
    if (frame_done)   begin fd_n++; fd_c = c; end
    if (frame_error)  fe_n++;
    @(negedge clk);
  endtask

  function automatic logic fbit(input int c, input logic [15:0] tag,
                                input logic [19:0] s1, input logic [19:0] s2,
                                input logic [19:0] s3, input logic [19:0] s4);
    logic [19:0] v;
    int n, b;
    if (c < 16) return tag[15-c];
    n = (c - 16) / 20 + 1;
    b = 19 - ((c - 16) % 20);
    case (n)
      1: v = s1;
      2: v = s2;
      3: v = s3;
      4: v = s4;
      default: v = 20'hA5C3F;
    endcase
    return v[b];
  endfunction

  // Bits 0..nbits-1 of a frame; SYNC high for bits 0..14, and at 255 when another frame follows.
  task automatic frame(input logic [15:0] tag, input logic [19:0] s1, input logic [19:0] s2,
                       input logic [19:0] s3, input logic [19:0] s4, input int nbits,
                       input logic next);
    for (int c = 0; c < nbits; c++)
      tick((c < 15) || (c == 255 && next), fbit(c, tag, s1, s2, s3, s4), 1'b0, c);
  endtask

  initial begin
    sync = 1'b0; sdata_in = 1'b0; rst = 1'b1;
    clr();
    @(negedge clk);
    tick(1'b0, 1'b0, 1'b1, 0);
    tick(1'b0, 1'b0, 1'b1, 0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 0);
    check("rst_locked", locked, 0);
    check("rst_ready", codec_ready, 0);
    check("rst_addr", status_addr, 0);
    check("rst_data", status_data, 0);
    check("rst_left", pcm_left, 0);
    check("rst_right", pcm_right, 0);
    check("rst_vld", {pcm_left_vld, pcm_right_vld}, 0);
    check("rst_pulses", sv_n + pv_n + fd_n + fe_n, 0);

    // Frame A: all valid
    clr();
    tick(1'b1, 1'b0, 1'b0, 255);
    frame(16'hF800, 20'h26000, 20'h000F0, 20'hABCDE, 20'h12345, 256, 1'b1);
    check("a_locked", locked, 1);
    check("a_ready", codec_ready, 1);
    check("a_addr", status_addr, 7'h26);
    check("a_data", status_data, 16'h000F);
    check("a_left", pcm_left, 20'hABCDE);
    check("a_right", pcm_right, 20'h12345);
    check("a_vld", {pcm_left_vld, pcm_right_vld}, 2'b11);
    check("a_sv_n", sv_n, 1);
    check("a_sv_c", sv_c, 55);
    check("a_pv_n", pv_n, 1);
    check("a_pv_c", pv_c, 95);
    check("a_fd_n", fd_n, 1);
    check("a_fd_c", fd_c, 255);
    check("a_left16", left16, 16'hABCD);
    check("a_right16", right16, 16'h1234);

    // Frame B: ready + slot 3 only
    clr();
    frame(16'h9000, 20'h7F000, 20'hFFFF0, 20'h55555, 20'hFFFFF, 256, 1'b1);
    check("b_sv_n", sv_n, 0);
    check("b_addr", status_addr, 7'h26);
    check("b_data", status_data, 16'h000F);
    check("b_pv_n", pv_n, 1);
    check("b_left", pcm_left, 20'h55555);
    check("b_right", pcm_right, 20'h12345);
    check("b_vld", {pcm_left_vld, pcm_right_vld}, 2'b10);
    check("b_left16", left16, 16'h5555);
    check("b_fd_n", fd_n, 1);

    // Frame C: empty tag
    clr();
    frame(16'h0000, 20'h11111, 20'h22222, 20'h33333, 20'h44444, 256, 1'b1);
    check("c_ready", codec_ready, 0);
    check("c_sv_n", sv_n, 0);
    check("c_pv_n", pv_n, 0);
    check("c_fd_n", fd_n, 1);
    check("c_left", pcm_left, 20'h55555);

    // Partial frame, SYNC re-rises at c=40
    clr();
    frame(16'hF800, 20'h3F000, 20'h99990, 20'h66666, 20'h77777, 40, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 40);
    check("p_pulses", sv_n + pv_n + fd_n, 0);
    check("p_ferr", fe_n, 0);
    check("p_locked", locked, 1);

    // Frame D decodes after resync
    clr();
    frame(16'hF800, 20'h11000, 20'hBEEF0, 20'h0F0F0, 20'hA5A5A, 256, 1'b1);
    check("d_sv_n", sv_n, 1);
    check("d_addr", status_addr, 7'h11);
    check("d_data", status_data, 16'hBEEF);
    check("d_pv_n", pv_n, 1);
    check("d_left", pcm_left, 20'h0F0F0);
    check("d_right", pcm_right, 20'hA5A5A);
    check("d_left16", left16, 16'h0F0F);
    check("d_right16", right16, 16'hA5A5);
    check("d_fd_n", fd_n, 1);

    // Reset asserted at c=70
    frame(16'hF800, 20'h22000, 20'h12340, 20'h11111, 20'h22222, 70, 1'b0);
    clr();
    tick(1'b0, 1'b1, 1'b1, 70);
    check("r_locked", locked, 0);
    check("r_ready", codec_ready, 0);
    check("r_status", {status_addr, status_data}, 0);
    check("r_pcm", {pcm_left, pcm_right}, 0);
    check("r_vld", {pcm_left_vld, pcm_right_vld}, 0);
    for (int i = 0; i < 200; i++) tick(1'b0, 1'b1, 1'b0, 71 + i);
    check("r_idle_pulses", sv_n + pv_n + fd_n, 0);
    check("r_idle_locked", locked, 0);
    check("r_idle_ready", codec_ready, 0);

    // Frame F: status only
    clr();
    tick(1'b1, 1'b0, 1'b0, 255);
    frame(16'hE000, 20'h5A000, 20'h12340, 20'h77777, 20'h88888, 256, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 0);
    check("f_locked", locked, 1);
    check("f_ready", codec_ready, 1);
    check("f_sv_n", sv_n, 1);
    check("f_addr", status_addr, 7'h5A);
    check("f_data", status_data, 16'h1234);
    check("f_pv_n", pv_n, 0);
    check("f_left", pcm_left, 0);
    check("f_fd_n", fd_n, 1);
    check("f_ferr", fe_n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
